// File: rtl/db_req_arbiter.sv
// db_req_arbiter
//   Lets two Ethernet-side KVS requesters share one db_top lookup port.
//   Each port has a single-entry hold register. A round-robin grant picks one
//   held request per cycle and issues it to db_top. The port id of every issued
//   request is pushed into an in-order tag FIFO. Each db_top response pops that
//   FIFO and is steered back to the port that issued the request.
//
// Ports
//   clk, rst                        clock; synchronous active-high reset
//   p0_in_key/flag/valid            port0 request (no backpressure)
//   p0_out_valid/flag, p0_drop      port0 response, dropped-request pulse
//   p1_*                            same set for port1
//   db_in_key/flag/valid            request issued to db_top
//   db_out_valid/flag               db_top response (in issue order)
//   pend_cnt                        number of outstanding db requests
//   err_orphan                      sticky: response seen with no outstanding request
//
// Hold register FSM (one per port)
//   state | meaning
//   EMPTY | no request buffered; a strobe loads the register
//   FULL  | request buffered, waiting for grant; a strobe without grant is dropped

module db_req_arbiter #(
  parameter int KEY_SIZE   = 96,
  parameter int FLAG_SIZE  = 4,
  parameter int PEND_DEPTH = 8,
  parameter int PEND_ADDR  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_SIZE-1:0]  p0_in_key,
  input  logic [FLAG_SIZE-1:0] p0_in_flag,
  input  logic                 p0_in_valid,
  output logic                 p0_out_valid,
  output logic [FLAG_SIZE-1:0] p0_out_flag,
  output logic                 p0_drop,
  input  logic [KEY_SIZE-1:0]  p1_in_key,
  input  logic [FLAG_SIZE-1:0] p1_in_flag,
  input  logic                 p1_in_valid,
  output logic                 p1_out_valid,
  output logic [FLAG_SIZE-1:0] p1_out_flag,
  output logic                 p1_drop,
  output logic [KEY_SIZE-1:0]  db_in_key,
  output logic [FLAG_SIZE-1:0] db_in_flag,
  output logic                 db_in_valid,
  input  logic                 db_out_valid,
  input  logic [FLAG_SIZE-1:0] db_out_flag,
  output logic [PEND_ADDR:0]   pend_cnt,
  output logic                 err_orphan
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_state_t;

  localparam logic [PEND_ADDR:0] PEND_MAX = (PEND_ADDR + 1)'(PEND_DEPTH);

  hold_state_t hold0_q, hold0_d, hold1_q, hold1_d;

  logic [KEY_SIZE-1:0]  key0_q, key1_q;
  logic [FLAG_SIZE-1:0] flag0_q, flag1_q;

  // rr_q = 0 favours port0 when both ports hold a request
  logic rr_q;

  logic gnt0, gnt1, push, pop, pend_full, tag_head;
  logic load0, load1, drop0_d, drop1_d;

  logic [PEND_DEPTH-1:0] tag_mem;
  logic [PEND_ADDR-1:0]  wr_ptr, rd_ptr;

  // Grant, FIFO handshake and hold-register next state
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    hold0_d   = hold0_q;
    hold1_d   = hold1_q;
    // Full check uses the registered count, so a pop in this same cycle
    // does not free a slot until the next cycle.
    pend_full = (pend_cnt == PEND_MAX);

    if (!pend_full) begin
      if (hold0_q == FULL && hold1_q == FULL) begin
        gnt0 = ~rr_q;
        gnt1 = rr_q;
      end else begin
        gnt0 = (hold0_q == FULL);
        gnt1 = (hold1_q == FULL);
      end
    end

    push     = gnt0 | gnt1;
    pop      = db_out_valid && (pend_cnt != '0);
    tag_head = tag_mem[rd_ptr];

    case (hold0_q)
      EMPTY:   if (p0_in_valid) hold0_d = FULL;
      FULL:    if (gnt0 && !p0_in_valid) hold0_d = EMPTY;
      default: hold0_d = EMPTY;
    endcase

    case (hold1_q)
      EMPTY:   if (p1_in_valid) hold1_d = FULL;
      FULL:    if (gnt1 && !p1_in_valid) hold1_d = EMPTY;
      default: hold1_d = EMPTY;
    endcase

    // A strobe is accepted when the register is empty or being vacated now
    load0   = p0_in_valid && (hold0_q == EMPTY || gnt0);
    load1   = p1_in_valid && (hold1_q == EMPTY || gnt1);
    drop0_d = p0_in_valid && (hold0_q == FULL) && !gnt0;
    drop1_d = p1_in_valid && (hold1_q == FULL) && !gnt1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold0_q <= EMPTY;
      hold1_q <= EMPTY;
    end else begin
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
    end
  end

  // Hold register payloads
  always_ff @(posedge clk) begin
    if (rst) begin
      key0_q  <= '0;
      flag0_q <= '0;
      key1_q  <= '0;
      flag1_q <= '0;
    end else begin
      if (load0) begin
        key0_q  <= p0_in_key;
        flag0_q <= p0_in_flag;
      end
      if (load1) begin
        key1_q  <= p1_in_key;
        flag1_q <= p1_in_flag;
      end
    end
  end

  // Round-robin pointer only moves when it actually decided a contention
  always_ff @(posedge clk) begin
    if (rst)
      rr_q <= 1'b0;
    else if (hold0_q == FULL && hold1_q == FULL && push)
      rr_q <= ~rr_q;
  end

  // Tag storage: 0 = port0, 1 = port1
  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr] <= gnt1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pend_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      db_in_valid  <= 1'b0;
      db_in_key    <= '0;
      db_in_flag   <= '0;
      p0_out_valid <= 1'b0;
      p0_out_flag  <= '0;
      p0_drop      <= 1'b0;
      p1_out_valid <= 1'b0;
      p1_out_flag  <= '0;
      p1_drop      <= 1'b0;
      err_orphan   <= 1'b0;
    end else begin
      db_in_valid <= push;
      if (gnt0) begin
        db_in_key  <= key0_q;
        db_in_flag <= flag0_q;
      end else if (gnt1) begin
        db_in_key  <= key1_q;
        db_in_flag <= flag1_q;
      end

      p0_out_valid <= pop && !tag_head;
      p1_out_valid <= pop && tag_head;
      if (pop && !tag_head) p0_out_flag <= db_out_flag;
      if (pop && tag_head)  p1_out_flag <= db_out_flag;

      p0_drop <= drop0_d;
      p1_drop <= drop1_d;

      if (db_out_valid && pend_cnt == '0)
        err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_db_req_arbiter.sv
module tb_db_req_arbiter;

  localparam int KS = 96;
  localparam int FS = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [KS-1:0] p0_in_key = '0, p1_in_key = '0;
  logic [FS-1:0] p0_in_flag = '0, p1_in_flag = '0;
  logic          p0_in_valid = 1'b0, p1_in_valid = 1'b0;
  logic          p0_out_valid, p1_out_valid, p0_drop, p1_drop;
  logic [FS-1:0] p0_out_flag, p1_out_flag;
  logic [KS-1:0] db_in_key;
  logic [FS-1:0] db_in_flag;
  logic          db_in_valid;
  logic          db_out_valid = 1'b0;
  logic [FS-1:0] db_out_flag = '0;
  logic [3:0]    pend_cnt;
  logic          err_orphan;

  db_req_arbiter #(.KEY_SIZE(KS), .FLAG_SIZE(FS), .PEND_DEPTH(DEPTH), .PEND_ADDR(3)) dut (
    .clk(clk), .rst(rst),
    .p0_in_key(p0_in_key), .p0_in_flag(p0_in_flag), .p0_in_valid(p0_in_valid),
    .p0_out_valid(p0_out_valid), .p0_out_flag(p0_out_flag), .p0_drop(p0_drop),
    .p1_in_key(p1_in_key), .p1_in_flag(p1_in_flag), .p1_in_valid(p1_in_valid),
    .p1_out_valid(p1_out_valid), .p1_out_flag(p1_out_flag), .p1_drop(p1_drop),
    .db_in_key(db_in_key), .db_in_flag(db_in_flag), .db_in_valid(db_in_valid),
    .db_out_valid(db_out_valid), .db_out_flag(db_out_flag),
    .pend_cnt(pend_cnt), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entries; stamp = cycle at which the output must be visible
  typedef struct { logic [KS-1:0] key; logic [FS-1:0] flag; int stamp; } issue_t;
  typedef struct { int port; logic [FS-1:0] flag; int stamp; } resp_t;
  typedef struct { int pend; bit orphan; bit drop0; bit drop1; int stamp; } snap_t;

  issue_t exp_issue[$];
  resp_t  exp_resp[$];
  snap_t  exp_snap[$];

  // Reference model: transaction-level view of buffers, arbitration and tags
  bit            m_held[2];
  logic [KS-1:0] m_key[2];
  logic [FS-1:0] m_flag[2];
  int            m_rr;
  int            m_tags[$];
  bit            m_orphan;

  task automatic model_step(input bit r, input bit v0, input logic [KS-1:0] k0, input logic [FS-1:0] f0,
                            input bit v1, input logic [KS-1:0] k1, input logic [FS-1:0] f1,
                            input bit dv, input logic [FS-1:0] df);
    snap_t s;
    int sz, g, t;
    bit v[2];
    logic [KS-1:0] k[2];
    logic [FS-1:0] f[2];
    v[0] = v0; v[1] = v1; k[0] = k0; k[1] = k1; f[0] = f0; f[1] = f1;
    s.drop0 = 0; s.drop1 = 0; s.stamp = cyc + 1;
    if (r) begin
      m_held[0] = 0; m_held[1] = 0; m_rr = 0; m_orphan = 0;
      m_tags.delete(); exp_issue.delete(); exp_resp.delete();
    end else begin
      sz = m_tags.size();
      g = -1;
      if (sz < DEPTH) begin
        if (m_held[0] && m_held[1]) begin g = m_rr; m_rr = 1 - m_rr; end
        else if (m_held[0]) g = 0;
        else if (m_held[1]) g = 1;
      end
      if (dv) begin
        if (sz > 0) begin
          t = m_tags.pop_front();
          exp_resp.push_back('{port: t, flag: df, stamp: cyc + 1});
        end else m_orphan = 1;
      end
      if (g >= 0) begin
        exp_issue.push_back('{key: m_key[g], flag: m_flag[g], stamp: cyc + 1});
        m_tags.push_back(g);
        m_held[g] = 0;
      end
      for (int p = 0; p < 2; p++) begin
        if (v[p]) begin
          if (m_held[p]) begin
            if (p == 0) s.drop0 = 1; else s.drop1 = 1;
          end else begin
            m_held[p] = 1; m_key[p] = k[p]; m_flag[p] = f[p];
          end
        end
      end
    end
    s.pend = m_tags.size();
    s.orphan = m_orphan;
    exp_snap.push_back(s);
  endtask

  task automatic drive_full(input bit r, input bit v0, input logic [KS-1:0] k0, input logic [FS-1:0] f0,
                            input bit v1, input logic [KS-1:0] k1, input logic [FS-1:0] f1,
                            input bit dv, input logic [FS-1:0] df);
    @(negedge clk);
    rst = r;
    p0_in_valid = v0; p0_in_key = k0; p0_in_flag = f0;
    p1_in_valid = v1; p1_in_key = k1; p1_in_flag = f1;
    db_out_valid = dv; db_out_flag = df;
    model_step(r, v0, k0, f0, v1, k1, f1, dv, df);
  endtask

  task automatic drive(input bit r, input bit v0, input bit v1, input bit dv);
    logic [KS-1:0] k0, k1;
    k0 = {$urandom(), $urandom(), $urandom()};
    k1 = {$urandom(), $urandom(), $urandom()};
    drive_full(r, v0, k0, FS'($urandom()), v1, k1, FS'($urandom()), dv, FS'($urandom()));
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard
  always @(posedge clk) begin
    issue_t ie;
    resp_t  re;
    snap_t  sn;
    #1;
    if (db_in_valid) begin
      if (exp_issue.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL issue_unexpected: actual db_in_valid=1 required 0 (cycle %0d)", cyc);
      end else begin
        ie = exp_issue.pop_front();
        chk("issue_key", 128'(db_in_key), 128'(ie.key));
        chk("issue_flag", 128'(db_in_flag), 128'(ie.flag));
        chk("issue_cycle", 128'(cyc), 128'(ie.stamp));
      end
    end else if (exp_issue.size() > 0 && exp_issue[0].stamp <= cyc) begin
      n_chk++; n_fail++;
      $display("FAIL issue_missing: actual db_in_valid=0 required 1 (cycle %0d)", cyc);
      void'(exp_issue.pop_front());
    end

    if (p0_out_valid || p1_out_valid) begin
      chk("resp_onehot", 128'(p0_out_valid & p1_out_valid), 128'(0));
      if (exp_resp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL resp_unexpected: actual out_valid p0=%0b p1=%0b required none (cycle %0d)",
                 p0_out_valid, p1_out_valid, cyc);
      end else begin
        re = exp_resp.pop_front();
        chk("resp_port", 128'(p1_out_valid ? 1 : 0), 128'(re.port));
        chk("resp_flag", 128'(p1_out_valid ? p1_out_flag : p0_out_flag), 128'(re.flag));
        chk("resp_cycle", 128'(cyc), 128'(re.stamp));
      end
    end else if (exp_resp.size() > 0 && exp_resp[0].stamp <= cyc) begin
      n_chk++; n_fail++;
      $display("FAIL resp_missing: actual out_valid=0 required port%0d (cycle %0d)", exp_resp[0].port, cyc);
      void'(exp_resp.pop_front());
    end

    while (exp_snap.size() > 0 && exp_snap[0].stamp < cyc) void'(exp_snap.pop_front());
    if (exp_snap.size() > 0 && exp_snap[0].stamp == cyc) begin
      sn = exp_snap.pop_front();
      chk("pend_cnt", 128'(pend_cnt), 128'(sn.pend));
      chk("err_orphan", 128'(err_orphan), 128'(sn.orphan));
      chk("p0_drop", 128'(p0_drop), 128'(sn.drop0));
      chk("p1_drop", 128'(p1_drop), 128'(sn.drop1));
    end
  end

  initial begin
    // Reset
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    @(negedge clk);
    chk("reset_db_in_key", 128'(db_in_key), 128'(0));
    chk("reset_db_in_flag", 128'(db_in_flag), 128'(0));
    chk("reset_p0_out_flag", 128'(p0_out_flag), 128'(0));

    // Single request on port0, response flag 8
    drive_full(0, 1, 96'h1, 4'h1, 0, '0, '0, 0, '0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
    drive_full(0, 0, '0, '0, 0, '0, '0, 1, 4'h8);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

    // Contention with instant responses
    for (int i = 0; i < 20; i++) drive(0, 1, 1, m_tags.size() > 0);
    for (int i = 0; i < 40 && (m_tags.size() > 0 || m_held[0] || m_held[1]); i++) drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

    // Fill the pending FIFO, then drops and full+pop
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 40 && (m_tags.size() > 0 || m_held[0] || m_held[1]); i++) drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

    // Orphan response
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      drive(0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) < 2);
    for (int i = 0; i < 40 && (m_tags.size() > 0 || m_held[0] || m_held[1]); i++) drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

    // Reset with 3 pending and both hold registers full
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 0);
    chk("pre_reset_pending", 128'(m_tags.size()), 128'(3));
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
    @(negedge clk);
    chk("post_reset_db_in_key", 128'(db_in_key), 128'(0));
    chk("post_reset_p0_flag", 128'(p0_out_flag), 128'(0));
    chk("post_reset_p1_flag", 128'(p1_out_flag), 128'(0));
    chk("post_reset_db_in_valid", 128'(db_in_valid), 128'(0));

    // Traffic works again after reset
    drive(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);

    @(negedge clk);
    chk("issue_queue_drained", 128'(exp_issue.size()), 128'(0));
    chk("resp_queue_drained", 128'(exp_resp.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
